string_expr_check: RTL and testbench

STRING_EXPR_CHECK -- requirements
Module: string_expr_check

---
 rtl/string_expr_check.sv | 183 ++++++++++++++++++
 tb/tb_string_expr_check.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/string_expr_check.sv
// string_expr_check
// Streaming syntax checker for simple arithmetic expressions made of decimal
// operands, the operators + - * /, and parentheses. One ASCII character is
// consumed per rising clock edge while in_valid is high. A newline restarts
// the check from a clean state.
//
// Ports:
//   clk       in   1              rising-edge clock
//   clr       in   1              asynchronous reset, active low
//   in_valid  in   1              qualifies 'in'
//   in        in   8              ASCII character
//   out       out  1              consumed prefix is a complete expression
//   err       out  1              stream malformed (sticky until NL/reset)
//   depth     out  clog2(D+1)     currently open parentheses
//   operands  out  CNT_W          operands started since reset/restart
module string_expr_check #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           in_valid,
  input  logic [7:0]                     in,
  output logic                           out,
  output logic                           err,
  output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
  output logic [CNT_W-1:0]               operands
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int DIG_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DIG_W-1:0]   DIG_MAX   = DIG_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   OPS_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {S_EXP, S_NUM, S_CLOSE, S_ERR} state_t;
  typedef enum logic [2:0] {C_DIG, C_OP, C_LP, C_RP, C_NL, C_OTH} class_t;

  // Map one ASCII character onto its token class.
  function automatic class_t classify(input logic [7:0] c);
    class_t cls;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      cls = C_DIG;
    end else if ((c == 8'h2B) || (c == 8'h2D) || (c == 8'h2A) || (c == 8'h2F)) begin
      cls = C_OP;
    end else if (c == 8'h28) begin
      cls = C_LP;
    end else if (c == 8'h29) begin
      cls = C_RP;
    end else if (c == 8'h0A) begin
      cls = C_NL;
    end else begin
      cls = C_OTH;
    end
    return cls;
  endfunction

  state_t             r_state;
  logic [DEPTH_W-1:0] r_depth;
  logic [DIG_W-1:0]   r_digits;
  logic [CNT_W-1:0]   r_operands;
  logic               r_out;
  logic               r_err;

  class_t             w_class;
  state_t             w_state_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic [DIG_W-1:0]   w_digits_nxt;
  logic [CNT_W-1:0]   w_ops_nxt;
  logic [CNT_W-1:0]   w_ops_inc;

  // Operand count increment that sticks at all-ones instead of wrapping.
  always_comb begin
    if (r_operands == OPS_MAX) begin
      w_ops_inc = r_operands;
    end else begin
      w_ops_inc = r_operands + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic: one transition per consumed character, no lookahead.
  always_comb begin
    w_class      = classify(in);
    w_state_nxt  = r_state;
    w_depth_nxt  = r_depth;
    w_digits_nxt = r_digits;
    w_ops_nxt    = r_operands;
    if (in_valid) begin
      if (w_class == C_NL) begin
        w_state_nxt  = S_EXP;
        w_depth_nxt  = '0;
        w_digits_nxt = '0;
        w_ops_nxt    = '0;
      end else begin
        case (r_state)
          S_EXP: begin
            case (w_class)
              C_DIG: begin
                w_state_nxt  = S_NUM;
                w_digits_nxt = DIG_W'(1);
                w_ops_nxt    = w_ops_inc;
              end
              C_LP: begin
                if (r_depth < DEPTH_MAX) begin
                  w_depth_nxt = r_depth + DEPTH_W'(1);
                end else begin
                  w_state_nxt = S_ERR;
                end
              end
              default: w_state_nxt = S_ERR;
            endcase
          end
          S_NUM: begin
            case (w_class)
              C_DIG: begin
                if (r_digits < DIG_MAX) begin
                  w_digits_nxt = r_digits + DIG_W'(1);
                end else begin
                  w_state_nxt = S_ERR;
                end
              end
              C_OP: w_state_nxt = S_EXP;
              C_RP: begin
                if (r_depth != '0) begin
                  w_state_nxt = S_CLOSE;
                  w_depth_nxt = r_depth - DEPTH_W'(1);
                end else begin
                  w_state_nxt = S_ERR;
                end
              end
              default: w_state_nxt = S_ERR;
            endcase
          end
          S_CLOSE: begin
            case (w_class)
              C_OP: w_state_nxt = S_EXP;
              C_RP: begin
                if (r_depth != '0) begin
                  w_depth_nxt = r_depth - DEPTH_W'(1);
                end else begin
                  w_state_nxt = S_ERR;
                end
              end
              default: w_state_nxt = S_ERR;
            endcase
          end
          S_ERR:   w_state_nxt = S_ERR;
          default: w_state_nxt = S_ERR;
        endcase
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counters and decoded flags; flags are registered from next state so
  // they reflect a character right after the edge that consumes it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_EXP;
      r_depth    <= '0;
      r_digits   <= '0;
      r_operands <= '0;
      r_out      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_depth    <= w_depth_nxt;
      r_digits   <= w_digits_nxt;
      r_operands <= w_ops_nxt;
      r_out      <= ((w_state_nxt == S_NUM) || (w_state_nxt == S_CLOSE)) &&
                    (w_depth_nxt == '0);
      r_err      <= (w_state_nxt == S_ERR);
    end
  end

  assign out      = r_out;
  assign err      = r_err;
  assign depth    = r_depth;
  assign operands = r_operands;

endmodule

// File: tb/tb_string_expr_check.sv
// Self-checking bench for string_expr_check (default parameters).
// Expected results are pushed to a scoreboard queue when a character (or an
// idle cycle) is driven, and popped/compared after the consuming edge.
module tb_string_expr_check;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_c;
  logic       out_s;
  logic       err_s;
  logic [1:0] depth_s;
  logic [7:0] ops_s;

  int n_vec;
  int n_bad;

  typedef struct {
    logic o;
    logic e;
    int   d;
    int   n;
  } exp_t;

  exp_t sb_q[$];

  string_expr_check #(.MAX_DIGITS(4), .MAX_DEPTH(3), .CNT_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .in_valid (in_valid),
    .in       (in_c),
    .out      (out_s),
    .err      (err_s),
    .depth    (depth_s),
    .operands (ops_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pop one scoreboard entry and compare all four outputs against it.
  task automatic compare(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      check_val({tag, " scoreboard-empty"}, 0, 1);
    end else begin
      x = sb_q.pop_front();
      check_val({tag, " out"},      int'(out_s),   int'(x.o));
      check_val({tag, " err"},      int'(err_s),   int'(x.e));
      check_val({tag, " depth"},    int'(depth_s), x.d);
      check_val({tag, " operands"}, int'(ops_s),   x.n);
    end
  endtask

  // Drive one cycle (valid or idle), then compare after the edge.
  task automatic drive(input string tag, input logic v, input byte c,
                       input logic eo, input logic ee, input int ed, input int en);
    exp_t x;
    x.o = eo; x.e = ee; x.d = ed; x.n = en;
    sb_q.push_back(x);
    in_valid = v;
    in_c     = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    compare(tag);
  endtask

  task automatic send(input string tag, input byte c,
                      input logic eo, input logic ee, input int ed, input int en);
    drive(tag, 1'b1, c, eo, ee, ed, en);
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_c     = 8'h00;

    // Reset state
    #12;
    sb_q.push_back('{1'b0, 1'b0, 0, 0});
    compare("reset");
    #3;
    clr = 1'b1;
    @(posedge clk);
    #1;

    // "1+2"
    send("1+2 c1", "1", 1'b1, 1'b0, 0, 1);
    send("1+2 c2", "+", 1'b0, 1'b0, 0, 1);
    send("1+2 c3", "2", 1'b1, 1'b0, 0, 2);
    send("nl a",   8'h0A, 1'b0, 1'b0, 0, 0);

    // "(3*45)"
    send("paren (", "(", 1'b0, 1'b0, 1, 0);
    send("paren 3", "3", 1'b0, 1'b0, 1, 1);
    send("paren *", "*", 1'b0, 1'b0, 1, 1);
    send("paren 4", "4", 1'b0, 1'b0, 1, 2);
    send("paren 5", "5", 1'b0, 1'b0, 1, 2);
    send("paren )", ")", 1'b1, 1'b0, 0, 2);
    send("nl b",    8'h0A, 1'b0, 1'b0, 0, 0);

    // "12345": fifth digit overflows
    send("dig 1", "1", 1'b1, 1'b0, 0, 1);
    send("dig 2", "2", 1'b1, 1'b0, 0, 1);
    send("dig 3", "3", 1'b1, 1'b0, 0, 1);
    send("dig 4", "4", 1'b1, 1'b0, 0, 1);
    send("dig 5", "5", 1'b0, 1'b1, 0, 1);
    send("err ignores dig", "7", 1'b0, 1'b1, 0, 1);
    send("nl c", 8'h0A, 1'b0, 1'b0, 0, 0);

    // "((((": depth overflow, frozen at 3
    send("lp 1", "(", 1'b0, 1'b0, 1, 0);
    send("lp 2", "(", 1'b0, 1'b0, 2, 0);
    send("lp 3", "(", 1'b0, 1'b0, 3, 0);
    send("lp 4", "(", 1'b0, 1'b1, 3, 0);
    send("err ignores rp", ")", 1'b0, 1'b1, 3, 0);
    send("nl d", 8'h0A, 1'b0, 1'b0, 0, 0);
    send("rp at 0", ")", 1'b0, 1'b1, 0, 0);
    send("nl e", 8'h0A, 1'b0, 1'b0, 0, 0);

    // Digit after ')' and ')' at depth 0 from NUM
    send("close (", "(", 1'b0, 1'b0, 1, 0);
    send("close 1", "1", 1'b0, 1'b0, 1, 1);
    send("close )", ")", 1'b1, 1'b0, 0, 1);
    send("close dig", "2", 1'b0, 1'b1, 0, 1);
    send("nl f", 8'h0A, 1'b0, 1'b0, 0, 0);
    send("num 9",  "9", 1'b1, 1'b0, 0, 1);
    send("num rp", ")", 1'b0, 1'b1, 0, 1);
    send("nl g", 8'h0A, 1'b0, 1'b0, 0, 0);

    // "1+", idle with 'x', then 'x' consumed, then NL
    send("hold 1", "1", 1'b1, 1'b0, 0, 1);
    send("hold +", "+", 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive("idle", 1'b0, "x", 1'b0, 1'b0, 0, 1);
    end
    send("oth x", "x", 1'b0, 1'b1, 0, 1);
    send("nl h", 8'h0A, 1'b0, 1'b0, 0, 0);

    // Operand counter saturation at 255
    for (int i = 1; i <= 260; i++) begin
      send("sat dig", "1", 1'b1, 1'b0, 0, (i > 255) ? 255 : i);
      send("sat op",  "+", 1'b0, 1'b0, 0, (i > 255) ? 255 : i);
    end
    send("nl i", 8'h0A, 1'b0, 1'b0, 0, 0);

    // "(7" then asynchronous reset between edges
    send("ar (", "(", 1'b0, 1'b0, 1, 0);
    send("ar 7", "7", 1'b0, 1'b0, 1, 1);
    #2;
    clr = 1'b0;
    #1;
    sb_q.push_back('{1'b0, 1'b0, 0, 0});
    compare("async reset");
    #4;
    clr = 1'b1;
    @(posedge clk);
    #1;
    send("post reset 5", "5", 1'b1, 1'b0, 0, 1);

    check_val("scoreboard drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
